// File: rtl/nios2_mult_pkg.sv
// Shared types and constants for the shared 32x32 (low word) multiplier sequencer.
package nios2_mult_pkg;

  localparam int MUL_W    = 32;
  localparam int HALF_W   = 16;
  localparam int CELL_LAT = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Low word of a*b from the three 16x16 partials; the hi*hi term never reaches the low word.
  function automatic logic [MUL_W-1:0] combine(input logic [MUL_W-1:0] p1,
                                               input logic [MUL_W-1:0] p2,
                                               input logic [MUL_W-1:0] p3);
    return p1 + ((p2 + p3) << HALF_W);
  endfunction

endpackage

// File: rtl/mult_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, wrapping.
module mult_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/nios2_mult_share_arbiter.sv
// Shares one registered 3-product multiplier cell between NUM_REQ requesters,
// one transaction at a time: grant, issue, capture/combine, hold response.
module nios2_mult_share_arbiter
  import nios2_mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [MUL_W*NUM_REQ-1:0] req_src1,
  input  logic [MUL_W*NUM_REQ-1:0] req_src2,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [MUL_W-1:0]         rsp_result,
  output logic [MUL_W-1:0]         cell_src1,
  output logic [MUL_W-1:0]         cell_src2,
  output logic                     cell_en,
  input  logic [MUL_W-1:0]         cell_p1,
  input  logic [MUL_W-1:0]         cell_p2,
  input  logic [MUL_W-1:0]         cell_p3,
  output logic                     busy
);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cur_id;
  logic [MUL_W-1:0]  op_a, op_b;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;

  mult_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    cell_en   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (grant_any) state_nxt = ISSUE;
      end
      ISSUE: begin
        cell_en   = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latches feed the cell directly, so cell inputs only move on a grant.
  assign cell_src1 = op_a;
  assign cell_src2 = op_b;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      cur_id     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          op_a   <= req_src1[MUL_W*grant_idx +: MUL_W];
          op_b   <= req_src2[MUL_W*grant_idx +: MUL_W];
          cur_id <= grant_idx;
          rr_ptr <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
        CAPTURE: begin
          rsp_result <= combine(cell_p1, cell_p2, cell_p3);
          rsp_id     <= cur_id;
          rsp_valid  <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_mult_share_arbiter.sv
// Randomized + directed bench: behavioural round-robin/latency model and a response scoreboard.
module tb_nios2_mult_share_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [32*N-1:0] req_src1 = '0, req_src2 = '0;
  logic          rsp_valid, rsp_ready = 1'b1;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_result, cell_src1, cell_src2;
  logic          cell_en, busy;
  logic [31:0]   cell_p1 = '0, cell_p2 = '0, cell_p3 = '0;

  nios2_mult_share_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .cell_src1(cell_src1), .cell_src2(cell_src2),
    .cell_en(cell_en), .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3), .busy(busy));

  always #5 clk = ~clk;

  // Multiplier cell model: registered 16x16 partials, captured only when enabled.
  always @(posedge clk) if (cell_en) begin
    cell_p1 <= 32'(cell_src1[15:0])  * 32'(cell_src2[15:0]);
    cell_p2 <= 32'(cell_src1[15:0])  * 32'(cell_src2[31:16]);
    cell_p3 <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [31:0] res; int gcyc; bit seen; } exp_t;
  exp_t sb[$];

  int vectors = 0, miscompares = 0;

  // Model state: one transaction in flight; phase 1..3 = cycles after the grant edge.
  bit          outstanding = 0;
  int          phase = 0, mptr = 0;
  logic [31:0] cur_a, cur_b;
  bit [N-1:0]  consumed = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    int g;
    logic [N-1:0] exp_rdy;
    if (reset) begin
      outstanding = 0; mptr = 0; sb.delete();
      return;
    end
    if (outstanding) begin
      if (phase < 3) phase++;
      chk("req_ready_busy", 32'(req_ready), 32'h0);
      chk("cell_en", 32'(cell_en), 32'(phase == 1));
      chk("busy", 32'(busy), 32'h1);
      chk("rsp_valid_timing", 32'(rsp_valid), 32'(phase == 3));
      if (phase == 1) begin
        chk("cell_src1", cell_src1, cur_a);
        chk("cell_src2", cell_src2, cur_b);
      end
      if (phase == 3 && rsp_ready) outstanding = 0;
    end else begin
      chk("busy_idle", 32'(busy), 32'h0);
      chk("rsp_valid_idle", 32'(rsp_valid), 32'h0);
      chk("cell_en_idle", 32'(cell_en), 32'h0);
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready_grant", 32'(req_ready), 32'(exp_rdy));
      if (g >= 0) begin
        cur_a = req_src1[g*32 +: 32];
        cur_b = req_src2[g*32 +: 32];
        sb.push_back('{id: g, res: cur_a * cur_b, gcyc: cyc, seen: 0});
        mptr = (g + 1) % N;
        outstanding = 1; phase = 0;
        consumed[g] = 1'b1;
      end
    end
  endtask

  // Monitor: compare every cycle the response is presented; pop on handshake.
  always @(negedge clk) if (!reset && rsp_valid) begin
    if (sb.size() == 0) begin
      chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
    end else begin
      chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
      chk("rsp_result", rsp_result, sb[0].res);
      if (!sb[0].seen) begin
        chk("latency", 32'(cyc - sb[0].gcyc), 32'd3);
        sb[0].seen = 1;
      end
      if (rsp_ready) void'(sb.pop_front());
    end
  end

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = 1'b1;
    req_src1[i*32 +: 32] = a;
    req_src2[i*32 +: 32] = b;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return {16'h0, 16'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    consumed = '0;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cell_en", 32'(cell_en), 32'h0);
    chk("rst_cell_src1", cell_src1, 32'h0);
    chk("rst_cell_src2", cell_src2, 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
  endtask

  task automatic wait_grant(input int i);
    int n = 0;
    while (!consumed[i] && n < 20) begin tick(); n++; end
    chk("grant_timeout", 32'(consumed[i]), 32'h1);
    req_valid[i] = 1'b0;
    consumed[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (outstanding && n < 40) begin tick(); n++; end
    chk("idle_timeout", 32'(outstanding), 32'h0);
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
    set_req(i, a, b);
    wait_grant(i);
    wait_idle();
  endtask

  initial begin
    int order[$];
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    @(posedge clk); #1;
    do_reset();

    // Basic, wrap-around and overflow products.
    rsp_ready = 1'b1;
    issue(0, 32'h0001_0003, 32'h0002_0005);
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2, 32'h8000_0000, 32'h0000_0002);

    // All requesters held valid from rr_ptr=0.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom);
    for (int n = 0; n < 40 && order.size() < 5; n++) begin
      tick();
      for (int i = 0; i < N; i++) if (consumed[i]) begin
        order.push_back(i);
        consumed[i] = 1'b0;
        set_req(i, $urandom, $urandom);
      end
    end
    req_valid = '0;
    wait_idle();
    chk("rr_order_count", 32'(order.size()), 32'd5);
    for (int k = 0; k < 5 && k < order.size(); k++)
      chk("rr_order", 32'(order[k]), 32'(exp_order[k]));

    // Backpressure: response held for ~10 cycles.
    rsp_ready = 1'b0;
    set_req(0, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_grant(0);
    set_req(2, 32'h0000_0007, 32'h0000_0009);
    repeat (12) tick();
    rsp_ready = 1'b1;
    wait_grant(2);
    wait_idle();

    // Reset while in CAPTURE aborts; next request completes.
    set_req(1, 32'hDEAD_BEEF, 32'h0000_0003);
    wait_grant(1);
    tick();
    do_reset();
    tick();
    chk("abort_no_rsp", 32'(rsp_valid), 32'h0);
    issue(2, 32'h0003_0000, 32'h0000_0004);

    // Only req3 from rr_ptr=0; then pointer wraps to 0.
    do_reset();
    issue(3, 32'h0000_FFFF, 32'h0001_0001);
    set_req(0, 32'h5, 32'h6);
    set_req(2, 32'h7, 32'h8);
    tick();
    chk("wrap_to_req0", 32'(consumed), 32'h1);
    wait_grant(0);
    wait_grant(2);
    wait_idle();

    // Randomized traffic with random backpressure and withdrawn requests.
    for (int c = 0; c < 700; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (consumed[i]) begin req_valid[i] = 1'b0; consumed[i] = 1'b0; end
        if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, rnd_op(), rnd_op());
        else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();
    tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
